core_arbiter_n_to_1: RTL and testbench
======================================

CORE_ARBITER_N_TO_1 -- requirements
Module: core_arbiter_n_to_1

Interface
REQ-001 SHALL have parameters (one per line: name, default, meaning):
  NUM_CLIENTS 4 requesters, 2..16
  TEX_ADDR_W 24 texture address width
  WR_ADDR_W 32 write address width
  DATA_W 32 data width
  CORE_ID_W 7 core id width
  MAX_WAIT 7 aging threshold, in lost arbitrations
  TIMEOUT 255 max grant-hold cycles; 0 disables the timeout
REQ-002 SHALL have ports (name direction width meaning; clock and reset first; vectors packed, client i at slice i):
  clk in 1 single clock
  rst_n in 1 asynchronous active-low reset
  cli_tex_req in N texture request per client
  cli_tex_addr in N*TEX_ADDR_W texture address
  cli_tex_core_id in N*CORE_ID_W core id
  cli_tex_read_done in N client consumed read data
  cli_tex_valid out N texture data valid to client
  cli_tex_data out N*DATA_W texture data to client
  cli_wr_req in N write request
  cli_wr_addr in N*WR_ADDR_W write address
  cli_wr_data in N*DATA_W write data
  cli_wr_core_id in N*CORE_ID_W core id
  cli_wr_valid out N write valid to client
  cli_wr_done out N write done to client
  texture_req_out/texture_addr_out/texture_core_id_out/texture_read_done_out out 1/TEX_ADDR_W/CORE_ID_W/1 external texture port
  texture_valid_in/texture_data_in in 1/DATA_W external texture response
  write_req_out/write_addr_out/write_data_out/write_core_id_out out 1/WR_ADDR_W/DATA_W/CORE_ID_W external write port
  write_valid_in/write_done_in in 1/1 external write response
  tex_grant_id/wr_grant_id out $clog2(N) current owner, valid while busy
  tex_busy/wr_busy out 1 channel granted
  tex_timeout/wr_timeout out 1 one-cycle pulse on forced release
REQ-003 Clock clk; reset rst_n, asynchronous, active-low; no other clock or reset.

Function
REQ-004 Texture and write channels SHALL arbitrate independently and concurrently; each has states IDLE and GRANT.
REQ-005 IDLE with any request: grant registered at the clock edge; GRANT entered next cycle; external req asserts in the first GRANT cycle (1-cycle latency).
REQ-006 Selection order: first, the lowest-index client whose wait counter >= MAX_WAIT; otherwise round-robin, starting at rr_ptr.
REQ-007 Per-client wait counter (per channel):
  increment, saturating at MAX_WAIT, on each IDLE arbitration in which the client requests and is not selected;
  clear when the client is granted or its request is low.
REQ-008 In GRANT, outputs SHALL combinationally mux the owner's req/addr/core_id/read_done (or write fields) to the external port.
REQ-009 In GRANT, external responses SHALL route only to the owner's valid/data/done slice; all other slices read 0.
REQ-010 Texture release occurs on texture_valid_in && owner read_done; write release occurs on write_valid_in && write_done_in. On release: return to IDLE and set rr_ptr = owner+1 mod N.
REQ-011 If the owner drops its request in GRANT, the channel SHALL abort to IDLE next cycle; rr_ptr is not updated.
REQ-012 If TIMEOUT != 0 and GRANT persists for TIMEOUT cycles, the channel SHALL force release, pulse *_timeout for one cycle, and advance rr_ptr.
REQ-013 IDLE SHALL last at least one cycle between grants (one-cycle bubble).
REQ-014 With no requests in IDLE, all external outputs SHALL be 0.

Reset
REQ-015 Reset asserted SHALL immediately force both channels to IDLE, regardless of transaction in progress.
REQ-016 Reset values: rr_ptr = 0; wait counters = 0; timeout counters = 0; all outputs = 0.

Structure
REQ-017 A shared package arb_pkg SHALL hold the chan_state_t enum (IDLE, GRANT) and the clog2-derived width helpers.
REQ-018 Arbitration SHALL reside in one sub-module, rr_age_arbiter, instantiated once per channel; the top level contains only muxing and demuxing.

Verification (N=4, MAX_WAIT=7, TIMEOUT=255)
REQ-019 tex_req=0b0100 at cycle 0 -> cycle 1: tex_grant_id=2, texture_addr_out=client 2 addr; texture_valid_in && read_done[2] -> IDLE, rr_ptr=3.
REQ-020 tex_req=0b1111 held, each grant completed in 2 cycles -> grant order 0,1,2,3,0.
REQ-021 Clients 0 and 1 re-request continuously, client 3 requesting; rr_ptr steered to favour 0/1 -> client 3 granted no later than its 8th lost arbitration.
REQ-022 Texture grant to client 1 and write grant to client 2 concurrent -> both external ports active in the same cycle; responses reach only cli_tex_valid[1] and cli_wr_done[2].
REQ-023 Write owner never receives done -> at cycle 255 of GRANT: wr_timeout pulses, wr_busy=0 next cycle; rst_n low mid-GRANT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and width helpers for the N-to-1 core arbiter.
package arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } chan_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width able to hold 0..max_val, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_age_arbiter.sv
// Single-channel IDLE/GRANT arbiter: aged-first, then round-robin selection,
// with abort on request drop and an optional grant-hold timeout.
module rr_age_arbiter
    import arb_pkg::*;
#(
    parameter  int unsigned NUM_CLIENTS = 4,
    parameter  int unsigned MAX_WAIT    = 7,
    parameter  int unsigned TIMEOUT     = 255,
    localparam int unsigned ID_W        = id_w(NUM_CLIENTS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic                   done,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id,
    output logic                   timeout
);

    localparam int unsigned WAIT_W    = cnt_w(MAX_WAIT);
    localparam int unsigned HOLD_W    = cnt_w(TIMEOUT);
    localparam int unsigned HOLD_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    chan_state_t       state_q, state_n;
    logic [ID_W-1:0]   grant_q, grant_n;
    logic [ID_W-1:0]   rr_q, rr_n;
    logic [HOLD_W-1:0] hold_q, hold_n;
    logic [WAIT_W-1:0] wait_q [NUM_CLIENTS];
    logic [WAIT_W-1:0] wait_n [NUM_CLIENTS];
    logic              timeout_q, timeout_n;
    logic              any_req, aged_hit;
    logic [ID_W-1:0]   aged_idx, rr_idx, sel_idx, owner_next;

    assign any_req = |req;

    // Winner: lowest-index aged requester, else first requester from rr_q.
    always_comb begin : sel_p
        int c;
        aged_hit = 1'b0;
        aged_idx = '0;
        rr_idx   = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (req[i] && (wait_q[i] >= WAIT_W'(MAX_WAIT))) begin
                aged_hit = 1'b1;
                aged_idx = ID_W'(i);
            end
        end
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            c = int'(rr_q) + k;
            if (c >= int'(NUM_CLIENTS)) c = c - int'(NUM_CLIENTS);
            if (req[c]) rr_idx = ID_W'(c);
        end
        sel_idx = aged_hit ? aged_idx : rr_idx;
    end

    always_comb begin
        state_n    = state_q;
        grant_n    = grant_q;
        rr_n       = rr_q;
        hold_n     = hold_q;
        timeout_n  = 1'b0;
        owner_next = (grant_q == ID_W'(NUM_CLIENTS - 1)) ? '0 : grant_q + ID_W'(1);
        for (int i = 0; i < NUM_CLIENTS; i++) wait_n[i] = wait_q[i];

        case (state_q)
            IDLE: begin
                hold_n = '0;
                if (any_req) begin
                    state_n = GRANT;
                    grant_n = sel_idx;
                end
            end
            GRANT: begin
                hold_n = hold_q + HOLD_W'(1);
                if (done) begin
                    state_n = IDLE;
                    rr_n    = owner_next;
                end else if (!req[grant_q]) begin
                    state_n = IDLE;
                end else if ((TIMEOUT != 0) && (hold_q == HOLD_W'(HOLD_LAST))) begin
                    state_n = IDLE;
                    rr_n    = owner_next;
                end
                if (state_n == IDLE) begin
                    grant_n = '0;
                    hold_n  = '0;
                end
            end
            default: state_n = IDLE;
        endcase

        // Pulse lands in the last cycle a grant is allowed to hold.
        timeout_n = (TIMEOUT != 0) && (state_n == GRANT) && (hold_n == HOLD_W'(HOLD_LAST));

        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (!req[i]) begin
                wait_n[i] = '0;
            end else if ((state_q == IDLE) && any_req) begin
                if (sel_idx == ID_W'(i))
                    wait_n[i] = '0;
                else if (wait_q[i] < WAIT_W'(MAX_WAIT))
                    wait_n[i] = wait_q[i] + WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_q      <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
            for (int i = 0; i < NUM_CLIENTS; i++) wait_q[i] <= '0;
        end else begin
            state_q   <= state_n;
            grant_q   <= grant_n;
            rr_q      <= rr_n;
            hold_q    <= hold_n;
            timeout_q <= timeout_n;
            for (int i = 0; i < NUM_CLIENTS; i++) wait_q[i] <= wait_n[i];
        end
    end

    assign busy     = (state_q == GRANT);
    assign grant_id = grant_q;
    assign timeout  = timeout_q;

endmodule

// File: rtl/core_arbiter_n_to_1.sv
// N-to-1 arbiter for independent texture-read and write channels; one
// rr_age_arbiter per channel, this level only muxes requests and demuxes responses.
module core_arbiter_n_to_1
    import arb_pkg::*;
#(
    parameter  int unsigned NUM_CLIENTS = 4,
    parameter  int unsigned TEX_ADDR_W  = 24,
    parameter  int unsigned WR_ADDR_W   = 32,
    parameter  int unsigned DATA_W      = 32,
    parameter  int unsigned CORE_ID_W   = 7,
    parameter  int unsigned MAX_WAIT    = 7,
    parameter  int unsigned TIMEOUT     = 255,
    localparam int unsigned ID_W        = id_w(NUM_CLIENTS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CLIENTS-1:0]            cli_tex_req,
    input  logic [NUM_CLIENTS*TEX_ADDR_W-1:0] cli_tex_addr,
    input  logic [NUM_CLIENTS*CORE_ID_W-1:0]  cli_tex_core_id,
    input  logic [NUM_CLIENTS-1:0]            cli_tex_read_done,
    output logic [NUM_CLIENTS-1:0]            cli_tex_valid,
    output logic [NUM_CLIENTS*DATA_W-1:0]     cli_tex_data,
    input  logic [NUM_CLIENTS-1:0]            cli_wr_req,
    input  logic [NUM_CLIENTS*WR_ADDR_W-1:0]  cli_wr_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0]     cli_wr_data,
    input  logic [NUM_CLIENTS*CORE_ID_W-1:0]  cli_wr_core_id,
    output logic [NUM_CLIENTS-1:0]            cli_wr_valid,
    output logic [NUM_CLIENTS-1:0]            cli_wr_done,
    output logic                              texture_req_out,
    output logic [TEX_ADDR_W-1:0]             texture_addr_out,
    output logic [CORE_ID_W-1:0]              texture_core_id_out,
    output logic                              texture_read_done_out,
    input  logic                              texture_valid_in,
    input  logic [DATA_W-1:0]                 texture_data_in,
    output logic                              write_req_out,
    output logic [WR_ADDR_W-1:0]              write_addr_out,
    output logic [DATA_W-1:0]                 write_data_out,
    output logic [CORE_ID_W-1:0]              write_core_id_out,
    input  logic                              write_valid_in,
    input  logic                              write_done_in,
    output logic [ID_W-1:0]                   tex_grant_id,
    output logic [ID_W-1:0]                   wr_grant_id,
    output logic                              tex_busy,
    output logic                              wr_busy,
    output logic                              tex_timeout,
    output logic                              wr_timeout
);

    logic tex_done, wr_done;

    assign tex_done = texture_valid_in && texture_read_done_out;
    assign wr_done  = write_valid_in && write_done_in;

    rr_age_arbiter #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .MAX_WAIT    (MAX_WAIT),
        .TIMEOUT     (TIMEOUT)
    ) u_tex_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (cli_tex_req),
        .done     (tex_done),
        .busy     (tex_busy),
        .grant_id (tex_grant_id),
        .timeout  (tex_timeout)
    );

    rr_age_arbiter #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .MAX_WAIT    (MAX_WAIT),
        .TIMEOUT     (TIMEOUT)
    ) u_wr_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (cli_wr_req),
        .done     (wr_done),
        .busy     (wr_busy),
        .grant_id (wr_grant_id),
        .timeout  (wr_timeout)
    );

    // Texture channel: owner's fields out, external response back to owner only.
    always_comb begin
        texture_req_out       = 1'b0;
        texture_addr_out      = '0;
        texture_core_id_out   = '0;
        texture_read_done_out = 1'b0;
        cli_tex_valid         = '0;
        cli_tex_data          = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (tex_busy && (tex_grant_id == ID_W'(i))) begin
                texture_req_out       = cli_tex_req[i];
                texture_addr_out      = cli_tex_addr[i*TEX_ADDR_W +: TEX_ADDR_W];
                texture_core_id_out   = cli_tex_core_id[i*CORE_ID_W +: CORE_ID_W];
                texture_read_done_out = cli_tex_read_done[i];
                cli_tex_valid[i]      = texture_valid_in;
                cli_tex_data[i*DATA_W +: DATA_W] = texture_data_in;
            end
        end
    end

    // Write channel: same structure as the texture channel.
    always_comb begin
        write_req_out     = 1'b0;
        write_addr_out    = '0;
        write_data_out    = '0;
        write_core_id_out = '0;
        cli_wr_valid      = '0;
        cli_wr_done       = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (wr_busy && (wr_grant_id == ID_W'(i))) begin
                write_req_out     = cli_wr_req[i];
                write_addr_out    = cli_wr_addr[i*WR_ADDR_W +: WR_ADDR_W];
                write_data_out    = cli_wr_data[i*DATA_W +: DATA_W];
                write_core_id_out = cli_wr_core_id[i*CORE_ID_W +: CORE_ID_W];
                cli_wr_valid[i]   = write_valid_in;
                cli_wr_done[i]    = write_done_in;
            end
        end
    end

endmodule

// File: tb/tb_core_arbiter_n_to_1.sv
// Directed bench for core_arbiter_n_to_1 with N=4, MAX_WAIT=7, TIMEOUT=255.
module tb_core_arbiter_n_to_1;

    localparam int N   = 4;
    localparam int TAW = 24;
    localparam int WAW = 32;
    localparam int DW  = 32;
    localparam int CIW = 7;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      tex_req, tex_rd_done, tex_valid_cli;
    logic [N*TAW-1:0]  tex_addr;
    logic [N*CIW-1:0]  tex_cid, wr_cid;
    logic [N*DW-1:0]   tex_data_cli, wr_data;
    logic [N-1:0]      wr_req, wr_valid_cli, wr_done_cli;
    logic [N*WAW-1:0]  wr_addr;
    logic              texture_req_out, texture_read_done_out, texture_valid_in;
    logic [TAW-1:0]    texture_addr_out;
    logic [CIW-1:0]    texture_core_id_out, write_core_id_out;
    logic [DW-1:0]     texture_data_in, write_data_out;
    logic              write_req_out, write_valid_in, write_done_in;
    logic [WAW-1:0]    write_addr_out;
    logic [1:0]        tex_grant_id, wr_grant_id;
    logic              tex_busy, wr_busy, tex_timeout, wr_timeout;

    core_arbiter_n_to_1 #(
        .NUM_CLIENTS (N), .TEX_ADDR_W (TAW), .WR_ADDR_W (WAW), .DATA_W (DW),
        .CORE_ID_W (CIW), .MAX_WAIT (7), .TIMEOUT (255)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .cli_tex_req (tex_req), .cli_tex_addr (tex_addr), .cli_tex_core_id (tex_cid),
        .cli_tex_read_done (tex_rd_done), .cli_tex_valid (tex_valid_cli), .cli_tex_data (tex_data_cli),
        .cli_wr_req (wr_req), .cli_wr_addr (wr_addr), .cli_wr_data (wr_data), .cli_wr_core_id (wr_cid),
        .cli_wr_valid (wr_valid_cli), .cli_wr_done (wr_done_cli),
        .texture_req_out (texture_req_out), .texture_addr_out (texture_addr_out),
        .texture_core_id_out (texture_core_id_out), .texture_read_done_out (texture_read_done_out),
        .texture_valid_in (texture_valid_in), .texture_data_in (texture_data_in),
        .write_req_out (write_req_out), .write_addr_out (write_addr_out), .write_data_out (write_data_out),
        .write_core_id_out (write_core_id_out), .write_valid_in (write_valid_in), .write_done_in (write_done_in),
        .tex_grant_id (tex_grant_id), .wr_grant_id (wr_grant_id), .tex_busy (tex_busy), .wr_busy (wr_busy),
        .tex_timeout (tex_timeout), .wr_timeout (wr_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N-1:0] req;
        int           exp_id;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [TAW-1:0] taddr(input int i); return 24'hA0_0000 + 24'(i); endfunction
    function automatic logic [CIW-1:0] tcid(input int i);  return 7'h10 + 7'(i); endfunction
    function automatic logic [WAW-1:0] waddr(input int i); return 32'hB000_0000 + 32'(i); endfunction
    function automatic logic [DW-1:0]  wdat(input int i);  return 32'hD000_0000 + 32'(i); endfunction
    function automatic logic [CIW-1:0] wcid(input int i);  return 7'h20 + 7'(i); endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full texture transaction, starting and ending in IDLE just after an edge.
    task automatic tex_xact(input logic [N-1:0] req, input int exp_id, input int n);
        logic [N-1:0]    oh;
        logic [N*DW-1:0] ed;
        logic [DW-1:0]   td;
        tex_req = req;
        #1;
        chk($sformatf("v%0d_bubble_busy", n), tex_busy, 0);
        chk($sformatf("v%0d_idle_req_out", n), texture_req_out, 0);
        tick();
        chk($sformatf("v%0d_busy", n), tex_busy, 1);
        chk($sformatf("v%0d_grant", n), tex_grant_id, exp_id);
        chk($sformatf("v%0d_req_out", n), texture_req_out, 1);
        chk($sformatf("v%0d_addr", n), texture_addr_out, taddr(exp_id));
        chk($sformatf("v%0d_core_id", n), texture_core_id_out, tcid(exp_id));
        chk($sformatf("v%0d_no_early_valid", n), tex_valid_cli, 0);
        td = 32'hC0DE_0000 + 32'(n);
        oh = '0;
        oh[exp_id] = 1'b1;
        ed = '0;
        ed[exp_id*DW +: DW] = td;
        texture_valid_in = 1'b1;
        texture_data_in  = td;
        tex_rd_done      = oh;
        #1;
        chk($sformatf("v%0d_cli_valid", n), tex_valid_cli, oh);
        chk($sformatf("v%0d_cli_data", n), tex_data_cli, ed);
        chk($sformatf("v%0d_rd_done_out", n), texture_read_done_out, 1);
        tick();
        texture_valid_in = 1'b0;
        texture_data_in  = '0;
        tex_rd_done      = '0;
    endtask

    initial begin
        logic early;
        vecs[0]  = '{4'b0100, 2};
        vecs[1]  = '{4'b1001, 3};
        vecs[2]  = '{4'b1111, 0};
        vecs[3]  = '{4'b1111, 1};
        vecs[4]  = '{4'b1111, 2};
        vecs[5]  = '{4'b1111, 3};
        vecs[6]  = '{4'b1111, 0};
        vecs[7]  = '{4'b0101, 2};
        vecs[8]  = '{4'b0011, 0};
        vecs[9]  = '{4'b1000, 3};
        vecs[10] = '{4'b0110, 1};

        rst_n = 1'b0;
        tex_req = '0; tex_rd_done = '0; wr_req = '0;
        texture_valid_in = 1'b0; texture_data_in = '0;
        write_valid_in = 1'b0; write_done_in = 1'b0;
        for (int i = 0; i < N; i++) begin
            tex_addr[i*TAW +: TAW] = taddr(i);
            tex_cid[i*CIW +: CIW]  = tcid(i);
            wr_addr[i*WAW +: WAW]  = waddr(i);
            wr_data[i*DW +: DW]    = wdat(i);
            wr_cid[i*CIW +: CIW]   = wcid(i);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_tex_busy", tex_busy, 0);
        chk("rst_wr_busy", wr_busy, 0);
        chk("rst_grant_ids", {tex_grant_id, wr_grant_id}, 0);
        chk("rst_ext_req", {texture_req_out, write_req_out}, 0);
        chk("rst_ext_addr", {texture_addr_out, write_addr_out}, 0);
        chk("rst_timeouts", {tex_timeout, wr_timeout}, 0);
        chk("rst_cli_resp", {tex_valid_cli, wr_valid_cli, wr_done_cli}, 0);
        rst_n = 1'b1;
        tick();

        // Round-robin and single-request table on the texture channel.
        for (int v = 0; v < 11; v++) tex_xact(vecs[v].req, vecs[v].exp_id, v);

        // Steer rr_ptr to 0, then client 0 wins and aborts repeatedly while 3 ages.
        tex_xact(4'b1000, 3, 11);
        tex_req = 4'b1011;
        for (int r = 1; r <= 8; r++) begin
            tick();
            chk($sformatf("age_grant_r%0d", r), tex_grant_id, (r < 8) ? 0 : 3);
            if (r < 8) begin
                tex_req = 4'b1000;
                tick();
                chk($sformatf("age_abort_r%0d", r), tex_busy, 0);
                tex_req = 4'b1011;
            end
        end
        texture_valid_in = 1'b1;
        tex_rd_done = 4'b1000;
        tick();
        texture_valid_in = 1'b0;
        tex_rd_done = '0;
        tex_req = '0;

        // Concurrent texture and write grants.
        tex_req = 4'b0010;
        wr_req  = 4'b0100;
        tick();
        chk("conc_tex_grant", {tex_busy, tex_grant_id}, {1'b1, 2'd1});
        chk("conc_wr_grant", {wr_busy, wr_grant_id}, {1'b1, 2'd2});
        chk("conc_ext_reqs", {texture_req_out, write_req_out}, 2'b11);
        chk("conc_tex_addr", texture_addr_out, taddr(1));
        chk("conc_wr_addr", write_addr_out, waddr(2));
        chk("conc_wr_data", write_data_out, wdat(2));
        chk("conc_wr_core_id", write_core_id_out, wcid(2));
        texture_valid_in = 1'b1;
        texture_data_in  = 32'h1234_5678;
        tex_rd_done      = 4'b0010;
        write_valid_in   = 1'b1;
        write_done_in    = 1'b1;
        #1;
        chk("conc_cli_tex_valid", tex_valid_cli, 4'b0010);
        chk("conc_cli_wr_done", wr_done_cli, 4'b0100);
        chk("conc_cli_wr_valid", wr_valid_cli, 4'b0100);
        tick();
        texture_valid_in = 1'b0; texture_data_in = '0; tex_rd_done = '0;
        write_valid_in = 1'b0; write_done_in = 1'b0;
        tex_req = '0;
        wr_req = '0;
        chk("conc_release", {tex_busy, wr_busy}, 2'b00);

        // Abort on request drop leaves write rr_ptr at 3.
        wr_req = 4'b0001;
        tick();
        chk("abort_grant", {wr_busy, wr_grant_id}, {1'b1, 2'd0});
        wr_req = '0;
        tick();
        chk("abort_idle", {wr_busy, write_req_out}, 2'b00);
        wr_req = 4'b0011;
        tick();
        chk("abort_rr_kept", {wr_busy, wr_grant_id}, {1'b1, 2'd0});

        // Owner never gets done: forced release after 255 GRANT cycles.
        early = 1'b0;
        for (int c = 1; c <= 254; c++) begin
            if (wr_timeout || !wr_busy) early = 1'b1;
            tick();
        end
        chk("to_no_early_pulse", early, 0);
        chk("to_pulse_c255", wr_timeout, 1);
        chk("to_busy_c255", wr_busy, 1);
        tick();
        chk("to_busy_c256", wr_busy, 0);
        chk("to_pulse_c256", wr_timeout, 0);
        tex_req = 4'b0001;
        tick();
        chk("to_rr_advanced", {wr_busy, wr_grant_id}, {1'b1, 2'd1});
        chk("pre_rst_tex_grant", {tex_busy, tex_grant_id}, {1'b1, 2'd0});

        // Asynchronous reset in the middle of a cycle with both channels granted.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {tex_busy, wr_busy}, 2'b00);
        chk("arst_ext_req", {texture_req_out, write_req_out}, 2'b00);
        chk("arst_ext_fields", {texture_addr_out, write_addr_out, write_data_out}, 0);
        chk("arst_grant_ids", {tex_grant_id, wr_grant_id}, 0);
        tick();
        chk("arst_held", {tex_busy, wr_busy}, 2'b00);
        tex_req = 4'b1111;
        wr_req  = '0;
        rst_n   = 1'b1;
        tick();
        chk("post_rst_rr_zero", {tex_busy, tex_grant_id}, {1'b1, 2'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
